// File: rtl/mem_port_if.sv
// mem_port_if -- request/response bus between the CPU control sequencer and
// the memory port.
//
// Parameters:
//   ADDR_W  byte-address width
//
// Signals:
//   req    request, held by the master until it samples ack
//   we     1 = store, 0 = load/fetch
//   size   0 = byte, 1 = halfword, 2 = word, 3 = illegal
//   addr   byte address
//   wdata  store data, right-aligned
//   ack    one-cycle response strobe
//   err    request rejected (valid with ack)
//   rdata  load data, right-aligned, zero-extended (valid with ack)
//   busy   responder is processing a request
//
// Modports: master (requester side), slave (mem_port side).
interface mem_port_if #(
   parameter int ADDR_W = 16
) ();
   logic              req;
   logic              we;
   logic [1:0]        size;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              ack;
   logic              err;
   logic [31:0]       rdata;
   logic              busy;

   modport master (
      output req, we, size, addr, wdata,
      input  ack, err, rdata, busy
   );

   modport slave (
      input  req, we, size, addr, wdata,
      output ack, err, rdata, busy
   );
endinterface

// File: rtl/mem_port.sv
// mem_port -- memory-side responder for the CPU multi-cycle sequencer.
// Accepts one request at a time, drives a single-port synchronous SRAM with
// WAIT_CYCLES read-data wait cycles, steers byte lanes on writes and
// right-aligns read data. Every output is a register.
//
// Parameters:
//   ADDR_W       byte-address width (SRAM word address is ADDR_W-2 bits)
//   WAIT_CYCLES  wait cycles after the SRAM access cycle, legal 1..15
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   bus         request/response bus (mem_port_if.slave)
//   sram_en     SRAM access enable
//   sram_we     SRAM write enable, qualified by sram_en
//   sram_be     SRAM byte-lane enables
//   sram_addr   SRAM word address
//   sram_wdata  lane-replicated write data
//   sram_rdata  SRAM read data, valid one cycle after the enabled edge
//
// Build option:
//   MEM_PORT_ALIGN_CHECK_EN  when defined, misaligned halfword/word requests
//                            get an error response; otherwise the low address
//                            bits below the access size are ignored.
module mem_port #(
   parameter int ADDR_W      = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   mem_port_if.slave         bus,
   output logic              sram_en,
   output logic              sram_we,
   output logic [3:0]        sram_be,
   output logic [ADDR_W-3:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              op_we_q, op_we_d;
   logic [1:0]        op_size_q, op_size_d;
   logic [1:0]        op_off_q, op_off_d;
   logic              en_d, we_d;
   logic [3:0]        be_d;
   logic [ADDR_W-3:0] saddr_d;
   logic [31:0]       swdata_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              illegal;
   logic [3:0]        lane_be;
   logic [31:0]       lane_wdata;
   logic [31:0]       rd_steer;

   assign bus.ack   = ack_q;
   assign bus.err   = err_q;
   assign bus.busy  = busy_q;
   assign bus.rdata = rdata_q;

   // Lane enables and replicated write data for the request on the bus.
   // NOTE: every variable assigned in an always_comb gets a default first so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      illegal    = 1'b0;
      lane_be    = 4'b0000;
      lane_wdata = bus.wdata;
      case (bus.size)
         2'd0: begin
            lane_be    = 4'b0001 << bus.addr[1:0];
            lane_wdata = {4{bus.wdata[7:0]}};
         end
         2'd1: begin
            lane_be    = 4'b0011 << {bus.addr[1], 1'b0};
            lane_wdata = {2{bus.wdata[15:0]}};
`ifdef MEM_PORT_ALIGN_CHECK_EN
            illegal    = bus.addr[0];
`endif
         end
         2'd2: begin
            lane_be    = 4'b1111;
`ifdef MEM_PORT_ALIGN_CHECK_EN
            illegal    = |bus.addr[1:0];
`endif
         end
         default: illegal = 1'b1;
      endcase
   end

   // Read data: move the addressed lane(s) down to bit 0, zero above.
   always_comb begin
      rd_steer = sram_rdata;
      case (op_size_q)
         2'd0:    rd_steer = {24'h0, 8'(sram_rdata >> {op_off_q, 3'b000})};
         2'd1:    rd_steer = {16'h0, 16'(sram_rdata >> {op_off_q[1], 4'b0000})};
         default: rd_steer = sram_rdata;
      endcase
   end

   // Next state and next value of every registered output.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_we_d   = op_we_q;
      op_size_d = op_size_q;
      op_off_d  = op_off_q;
      en_d      = 1'b0;
      we_d      = 1'b0;
      be_d      = sram_be;
      saddr_d   = sram_addr;
      swdata_d  = sram_wdata;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      rdata_d   = rdata_q;

      case (state_q)
         IDLE: begin
            if (bus.req) begin
               op_we_d   = bus.we;
               op_size_d = bus.size;
               op_off_d  = bus.addr[1:0];
               if (illegal) begin
                  // Rejected: straight to the response, SRAM untouched.
                  state_d = RESP;
                  ack_d   = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  // SRAM controls are loaded here so they are valid for the
                  // whole ACCESS cycle.
                  state_d  = ACCESS;
                  en_d     = 1'b1;
                  we_d     = bus.we;
                  be_d     = lane_be;
                  saddr_d  = bus.addr[ADDR_W-1:2];
                  swdata_d = lane_wdata;
               end
            end
         end
         ACCESS: begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
               ack_d   = 1'b1;
               rdata_d = op_we_q ? 32'h0 : rd_steer;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed above.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         op_we_q    <= 1'b0;
         op_size_q  <= 2'd0;
         op_off_q   <= 2'd0;
         sram_en    <= 1'b0;
         sram_we    <= 1'b0;
         sram_be    <= 4'b0000;
         sram_addr  <= '0;
         sram_wdata <= 32'h0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         rdata_q    <= 32'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_we_q    <= op_we_d;
         op_size_q  <= op_size_d;
         op_off_q   <= op_off_d;
         sram_en    <= en_d;
         sram_we    <= we_d;
         sram_be    <= be_d;
         sram_addr  <= saddr_d;
         sram_wdata <= swdata_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         rdata_q    <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_port.sv
// tb_mem_port -- self-checking bench for mem_port.
// Contains a behavioural SRAM, a byte-addressed reference memory, a table of
// directed vectors, hand-written multi-cycle sequences (reset during a store,
// back-to-back requests) and a randomized phase checked against the
// reference model. Honours WAIT_CYCLES overrides and MEM_PORT_ALIGN_CHECK_EN.
module tb_mem_port;

   parameter int WAIT_CYCLES = 1;
   localparam int ADDR_W  = 16;
   localparam int TIMEOUT = 40;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              sram_en;
   logic              sram_we;
   logic [3:0]        sram_be;
   logic [ADDR_W-3:0] sram_addr;
   logic [31:0]       sram_wdata;
   logic [31:0]       sram_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_if #(.ADDR_W(ADDR_W)) bus ();

   mem_port #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_be    (sram_be),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural single-port synchronous SRAM.
   logic [31:0] sram_mem [2**(ADDR_W-2)];
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we) begin
            for (int b = 0; b < 4; b++)
               if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         end else begin
            sram_rdata <= sram_mem[sram_addr];
         end
      end
   end

   // Reference model: plain byte-addressed memory.
   logic [7:0] ref_mem [2**ADDR_W];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   // Expected outcome of one request, computed from the access rules.
   task automatic model_txn(input logic we, input logic [1:0] size,
                            input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                            output logic exp_err, output logic [31:0] exp_rd,
                            output logic [3:0] exp_be, output logic [31:0] exp_swd,
                            output logic [31:0] swd_mask);
      int nb;
      int ea;
      int lane;
      exp_err  = 1'b0;
      exp_rd   = 32'h0;
      exp_be   = 4'h0;
      exp_swd  = 32'h0;
      swd_mask = 32'h0;
      if (size == 2'd3) begin
         exp_err = 1'b1;
         return;
      end
      nb = 1 << size;
`ifdef MEM_PORT_ALIGN_CHECK_EN
      if ((int'(addr) % nb) != 0) begin
         exp_err = 1'b1;
         return;
      end
`endif
      ea = int'(addr) - (int'(addr) % nb);
      for (int i = 0; i < nb; i++) begin
         lane = (ea + i) % 4;
         exp_be[lane] = 1'b1;
         if (we) begin
            ref_mem[ea + i]         = wd[8*i +: 8];
            exp_swd[8*lane +: 8]  = wd[8*i +: 8];
            swd_mask[8*lane +: 8] = 8'hFF;
         end else begin
            exp_rd[8*i +: 8] = ref_mem[ea + i];
         end
      end
   endtask

   // Issues one request (req raised at a negedge, so the next posedge is the
   // sampling edge) and observes the DUT until ack or the cycle budget.
   task automatic do_txn(input logic we, input logic [1:0] size,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int en_cnt, output logic [3:0] be,
                         output logic [ADDR_W-3:0] saddr, output logic [31:0] swd,
                         output logic swe, output logic busy_ok, output logic done);
      rd = 0; er = 0; lat = 0; en_cnt = 0; be = 0; saddr = 0; swd = 0; swe = 0;
      busy_ok = 1'b1; done = 1'b0;
      @(negedge clk);
      bus.req   = 1'b1;
      bus.we    = we;
      bus.size  = size;
      bus.addr  = addr;
      bus.wdata = wd;
      for (int c = 1; c <= TIMEOUT; c++) begin
         @(posedge clk);
         #1;
         if (sram_en) begin
            en_cnt++;
            be    = sram_be;
            saddr = sram_addr;
            swd   = sram_wdata;
            swe   = sram_we;
         end
         if (!bus.busy) busy_ok = 1'b0;
         if (bus.ack) begin
            rd   = bus.rdata;
            er   = bus.err;
            lat  = c;
            done = 1'b1;
            break;
         end
      end
      // Drop req on the edge that samples ack.
      @(posedge clk);
      #1;
      bus.req = 1'b0;
   endtask

   task automatic run_check(input string tag, input logic we, input logic [1:0] size,
                            input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                            input logic exp_err, input logic [31:0] exp_rd,
                            input logic [3:0] exp_be, input logic [ADDR_W-3:0] exp_saddr,
                            input logic [31:0] exp_swd, input logic [31:0] swd_mask);
      logic [31:0]       rd, swd;
      logic              er, swe, busy_ok, done;
      int                lat, en_cnt;
      logic [3:0]        be;
      logic [ADDR_W-3:0] saddr;
      do_txn(we, size, addr, wd, rd, er, lat, en_cnt, be, saddr, swd, swe, busy_ok, done);
      check({tag, " ack seen"}, 32'(done), 32'd1);
      if (!done) return;
      check({tag, " err"}, 32'(er), 32'(exp_err));
      check({tag, " rdata"}, rd, exp_rd);
      check({tag, " latency"}, 32'(lat), exp_err ? 32'd1 : 32'(2 + WAIT_CYCLES));
      check({tag, " sram_en cycles"}, 32'(en_cnt), exp_err ? 32'd0 : 32'd1);
      check({tag, " busy held"}, 32'(busy_ok), 32'd1);
      if (!exp_err) begin
         check({tag, " sram_be"}, 32'(be), 32'(exp_be));
         check({tag, " sram_addr"}, 32'(saddr), 32'(exp_saddr));
         check({tag, " sram_we"}, 32'(swe), 32'(we));
         if (swd_mask != 32'h0)
            check({tag, " sram_wdata"}, swd & swd_mask, exp_swd & swd_mask);
      end
   endtask

   typedef struct {
      logic              we;
      logic [1:0]        size;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic              exp_err;
      logic [31:0]       exp_rd;
      logic [3:0]        exp_be;
      logic [ADDR_W-3:0] exp_saddr;
      logic [31:0]       exp_swd;
      logic [31:0]       swd_mask;
   } vec_t;

   vec_t vecs [13];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0]       rd, swd, exp_rd, exp_swd, mask;
      logic              er, swe, busy_ok, done, exp_err, rwe;
      int                lat, en_cnt;
      logic [3:0]        be, exp_be;
      logic [ADDR_W-3:0] saddr;
      logic [1:0]        rsize;
      logic [ADDR_W-1:0] raddr;
      logic [31:0]       rwd;
      bit                seen;

      for (int i = 0; i < 2**(ADDR_W-2); i++) sram_mem[i] = 32'h0;
      for (int i = 0; i < 2**ADDR_W; i++) ref_mem[i] = 8'h0;
      sram_rdata = 32'h0;

      //            we    size  addr      wdata         err   rdata         be     saddr    swd           mask
      vecs[0]  = '{1'b1, 2'd2, 16'h0010, 32'hDEADBEEF, 1'b0, 32'h00000000, 4'hF, 14'h004, 32'hDEADBEEF, 32'hFFFFFFFF};
      vecs[1]  = '{1'b0, 2'd2, 16'h0010, 32'h00000000, 1'b0, 32'hDEADBEEF, 4'hF, 14'h004, 32'h0,        32'h0};
      vecs[2]  = '{1'b1, 2'd0, 16'h0013, 32'h000000A5, 1'b0, 32'h00000000, 4'h8, 14'h004, 32'hA5A5A5A5, 32'hFFFFFFFF};
      vecs[3]  = '{1'b0, 2'd0, 16'h0013, 32'h00000000, 1'b0, 32'h000000A5, 4'h8, 14'h004, 32'h0,        32'h0};
      vecs[4]  = '{1'b1, 2'd2, 16'h0020, 32'h12345678, 1'b0, 32'h00000000, 4'hF, 14'h008, 32'h12345678, 32'hFFFFFFFF};
      vecs[5]  = '{1'b0, 2'd1, 16'h0022, 32'h00000000, 1'b0, 32'h00001234, 4'hC, 14'h008, 32'h0,        32'h0};
      vecs[6]  = '{1'b0, 2'd1, 16'h0020, 32'h00000000, 1'b0, 32'h00005678, 4'h3, 14'h008, 32'h0,        32'h0};
      vecs[7]  = '{1'b0, 2'd0, 16'h0021, 32'h00000000, 1'b0, 32'h00000056, 4'h2, 14'h008, 32'h0,        32'h0};
      vecs[8]  = '{1'b0, 2'd3, 16'h0010, 32'h00000000, 1'b1, 32'h00000000, 4'h0, 14'h000, 32'h0,        32'h0};
      vecs[9]  = '{1'b1, 2'd3, 16'h0030, 32'h77777777, 1'b1, 32'h00000000, 4'h0, 14'h000, 32'h0,        32'h0};
      vecs[10] = '{1'b1, 2'd2, 16'h0000, 32'hCAFEF00D, 1'b0, 32'h00000000, 4'hF, 14'h000, 32'hCAFEF00D, 32'hFFFFFFFF};
`ifdef MEM_PORT_ALIGN_CHECK_EN
      vecs[11] = '{1'b0, 2'd2, 16'h0002, 32'h00000000, 1'b1, 32'h00000000, 4'h0, 14'h000, 32'h0,        32'h0};
      vecs[12] = '{1'b0, 2'd1, 16'h0023, 32'h00000000, 1'b1, 32'h00000000, 4'h0, 14'h000, 32'h0,        32'h0};
`else
      vecs[11] = '{1'b0, 2'd2, 16'h0002, 32'h00000000, 1'b0, 32'hCAFEF00D, 4'hF, 14'h000, 32'h0,        32'h0};
      vecs[12] = '{1'b0, 2'd1, 16'h0023, 32'h00000000, 1'b0, 32'h00001234, 4'hC, 14'h008, 32'h0,        32'h0};
`endif

      // Reset state.
      reset_n   = 1'b0;
      bus.req   = 1'b0;
      bus.we    = 1'b0;
      bus.size  = 2'd0;
      bus.addr  = '0;
      bus.wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset ack/err/busy", {29'h0, bus.ack, bus.err, bus.busy}, 32'h0);
      check("reset sram_en/we/be", {26'h0, sram_en, sram_we, sram_be}, 32'h0);
      check("reset sram_addr", 32'(sram_addr), 32'h0);
      check("reset sram_wdata", sram_wdata, 32'h0);
      check("reset rdata", bus.rdata, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Directed table.
      for (int i = 0; i < 13; i++)
         run_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rd, vecs[i].exp_be,
                   vecs[i].exp_saddr, vecs[i].exp_swd, vecs[i].swd_mask);

      // Back-to-back: req held high through the first ack.
      @(negedge clk);
      bus.req   = 1'b1;
      bus.we    = 1'b1;
      bus.size  = 2'd2;
      bus.addr  = 16'h0050;
      bus.wdata = 32'h55AA33CC;
      seen = 1'b0;
      for (int c = 0; c < TIMEOUT; c++) begin
         @(posedge clk);
         #1;
         if (bus.ack) begin
            seen = 1'b1;
            break;
         end
      end
      check("b2b first ack", 32'(seen), 32'd1);
      bus.we   = 1'b0;
      bus.addr = 16'h0050;
      @(posedge clk);
      #1;
      check("b2b gap busy", 32'(bus.busy), 32'd0);
      check("b2b gap ack", 32'(bus.ack), 32'd0);
      @(posedge clk);
      #1;
      check("b2b second access sram_en", 32'(sram_en), 32'd1);
      check("b2b second access busy", 32'(bus.busy), 32'd1);
      seen = 1'b0;
      for (int c = 0; c < TIMEOUT; c++) begin
         @(posedge clk);
         #1;
         if (bus.ack) begin
            seen = 1'b1;
            break;
         end
      end
      check("b2b second ack", 32'(seen), 32'd1);
      check("b2b second rdata", bus.rdata, 32'h55AA33CC);
      check("b2b second err", 32'(bus.err), 32'd0);
      @(posedge clk);
      #1;
      bus.req = 1'b0;

      // Reset during the ACCESS cycle of a store.
      @(negedge clk);
      bus.req   = 1'b1;
      bus.we    = 1'b1;
      bus.size  = 2'd2;
      bus.addr  = 16'h0040;
      bus.wdata = 32'h11111111;
      @(posedge clk);
      #1;
      check("rst-mid access sram_we", 32'(sram_we), 32'd1);
      #2;
      reset_n = 1'b0;
      bus.req = 1'b0;
      #1;
      check("rst-mid sram_we drop", 32'(sram_we), 32'd0);
      check("rst-mid sram_en drop", 32'(sram_en), 32'd0);
      check("rst-mid busy", 32'(bus.busy), 32'd0);
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (bus.ack) seen = 1'b1;
      end
      check("rst-mid no ack", 32'(seen), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      run_check("rst-mid reload", 1'b0, 2'd2, 16'h0040, 32'h0, 1'b0, 32'h0,
                4'hF, 14'h010, 32'h0, 32'h0);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 200; n++) begin
         rwe   = 1'($urandom_range(0, 1));
         rsize = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         raddr = 16'h0100 + 16'($urandom_range(0, 63));
         rwd   = $urandom;
         model_txn(rwe, rsize, raddr, rwd, exp_err, exp_rd, exp_be, exp_swd, mask);
         run_check($sformatf("rand%0d", n), rwe, rsize, raddr, rwd, exp_err, exp_rd,
                   exp_be, raddr[ADDR_W-1:2], exp_swd, mask);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
